pipe_reg_chain: RTL and testbench

Parametrised successor to the single-stage pipe register: a DEPTH-stage elastic pipeline with per-stage valid bits, a valid/ready handshake on both ends, bubble collapsing and synchronous flush. It sits between producer and consumer datapath blocks wherever multi-cycle register slicing with backpressure is needed. It also reports occupancy (count/empty/full) for upstream flow control.

---
 rtl/pipe_reg_chain.sv | 139 +++++++++++++
 tb/tb_pipe_reg_chain.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain
// ---------------------------------------------------------------------------
// DEPTH-stage elastic register pipeline with a valid/ready handshake on both
// ends. Each stage has its own valid bit. A valid word always moves forward
// into an empty next stage, so bubbles close up even while the output is
// stalled. Words leave in strict FIFO order. The block also reports its
// occupancy so upstream logic can do flow control.
//
// Parameters:
//   DSIZE      data width in bits (>=1)
//   DEPTH      number of register stages (>=2)
//   CLR_ON_POP 1 = a vacated stage has its data zeroed, 0 = the stale data stays
//
// Ports:
//   clock    in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   in_vld   in   upstream word valid
//   in_rdy   out  chain can accept a word this cycle
//   indata   in   upstream data [DSIZE]
//   out_vld  out  output stage (DEPTH-1) holds valid data
//   out_rdy  in   downstream accepts outdata this cycle
//   outdata  out  data of stage DEPTH-1 [DSIZE]
//   flush    in   synchronous clear of all stages (highest priority)
//   count    out  number of valid stages, 0..DEPTH [CW]
//   empty    out  count == 0
//   full     out  count == DEPTH
// ---------------------------------------------------------------------------
module pipe_reg_chain #(
  parameter int DSIZE      = 8,
  parameter int DEPTH      = 4,
  parameter int CLR_ON_POP = 1,
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [DSIZE-1:0] indata,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [DSIZE-1:0] outdata,
  input  logic             flush,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [DEPTH-1:0] vld_q;
  logic [DSIZE-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] move;
  logic             push;
  logic             pop;
  logic [CW-1:0]    count_q;

  // Advance terms, computed from the output end back towards the input.
  // A stage may hand its word on when the next stage is empty or is itself
  // handing its word on this cycle. This ripple is what lets a pop at the
  // output make room at the input in the same cycle (out_rdy -> in_rdy).
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = out_rdy;
    for (int k = DEPTH - 2; k >= 0; k--) begin
      adv[k] = !vld_q[k+1] | adv[k+1];
    end
  end

  // A stage's word leaves it this cycle when it is valid and may advance.
  // For the last stage this is exactly the pop condition.
  assign move = vld_q & adv;

  // Flush blocks input so a word offered during flush is dropped, not
  // captured into a chain that is about to be cleared.
  assign in_rdy = !flush & (!vld_q[0] | adv[0]);
  assign push   = in_vld & in_rdy;
  assign pop    = move[DEPTH-1];

  // Stage registers. Stage 0 loads from the input; every later stage loads
  // from its predecessor when that word moves. A stage that hands its word
  // on and receives nothing new goes invalid and, depending on CLR_ON_POP,
  // has its data zeroed so outdata reads 0 while the output is idle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else if (flush) begin
      vld_q <= '0;
      if (CLR_ON_POP != 0) begin
        for (int k = 0; k < DEPTH; k++) begin
          data_q[k] <= '0;
        end
      end
    end else begin
      if (push) begin
        vld_q[0]  <= 1'b1;
        data_q[0] <= indata;
      end else if (move[0]) begin
        vld_q[0] <= 1'b0;
        if (CLR_ON_POP != 0) begin
          data_q[0] <= '0;
        end
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (move[k-1]) begin
          vld_q[k]  <= 1'b1;
          data_q[k] <= data_q[k-1];
        end else if (move[k]) begin
          vld_q[k] <= 1'b0;
          if (CLR_ON_POP != 0) begin
            data_q[k] <= '0;
          end
        end
      end
    end
  end

  // Occupancy counter. A push and a pop in the same cycle cancel out; a
  // flush empties the chain even if a word was popped in that cycle.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, pop};
    end
  end

  assign out_vld = vld_q[DEPTH-1];
  assign outdata = data_q[DEPTH-1];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain
// ---------------------------------------------------------------------------
// Directed bench for pipe_reg_chain with DSIZE=8, DEPTH=4, CLR_ON_POP=1.
// A table of per-cycle vectors covers latency, backpressure with bubble
// collapse, and flush. Hand-written sequences cover reset, streaming and an
// asynchronous reset in the middle of operation.
// Each vector drives inputs shortly after a rising edge, then samples the
// state registered at that edge together with the combinational in_rdy.
// ---------------------------------------------------------------------------
module tb_pipe_reg_chain;

  localparam int DSIZE = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clock;
  logic             rst_n;
  logic             in_vld;
  logic             in_rdy;
  logic [DSIZE-1:0] indata;
  logic             out_vld;
  logic             out_rdy;
  logic [DSIZE-1:0] outdata;
  logic             flush;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;

  int checks;
  int failures;

  typedef struct {
    logic       in_vld;
    logic [7:0] indata;
    logic       out_rdy;
    logic       flush;
    logic       exp_vld;
    logic [7:0] exp_data;
    int         exp_count;
    logic       exp_rdy;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  pipe_reg_chain #(
    .DSIZE(DSIZE),
    .DEPTH(DEPTH),
    .CLR_ON_POP(1)
  ) dut (
    .clock(clock),
    .rst_n(rst_n),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .indata(indata),
    .out_vld(out_vld),
    .out_rdy(out_rdy),
    .outdata(outdata),
    .flush(flush),
    .count(count),
    .empty(empty),
    .full(full)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run always ends even if the sequencing goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic ordy,
                              input logic fl, input logic ev, input logic [7:0] ed,
                              input int ec, input logic er, input string tag);
    vec_t v;
    v.in_vld    = iv;
    v.indata    = d;
    v.out_rdy   = ordy;
    v.flush     = fl;
    v.exp_vld   = ev;
    v.exp_data  = ed;
    v.exp_count = ec;
    v.exp_rdy   = er;
    v.tag       = tag;
    return v;
  endfunction

  task automatic applyStimulus(input logic iv, input logic [7:0] d,
                               input logic ordy, input logic fl);
    in_vld  = iv;
    indata  = d;
    out_rdy = ordy;
    flush   = fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Compare every observable output against one expected state.
  task automatic checkState(input string tag, input logic ev, input logic [7:0] ed,
                            input int ec, input logic er);
    checkOutput({tag, ".out_vld"}, 32'(out_vld), 32'(ev));
    checkOutput({tag, ".outdata"}, 32'(outdata), 32'(ed));
    checkOutput({tag, ".count"},   32'(count),   32'(ec));
    checkOutput({tag, ".in_rdy"},  32'(in_rdy),  32'(er));
    checkOutput({tag, ".empty"},   32'(empty),   32'(ec == 0));
    checkOutput({tag, ".full"},    32'(full),    32'(ec == DEPTH));
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // ---- Reset / idle ----
    repeat (3) @(posedge clock);
    #3;
    checkState("reset_held", 1'b0, 8'h00, 0, 1'b1);
    rst_n = 1'b1;
    #1;
    checkState("reset_released", 1'b0, 8'h00, 0, 1'b1);
    nextCycle();

    // ---- Vector table ----
    // Latency: one push, visible at the output four edges later, then popped.
    vecs.push_back(mk(1, 8'hA5, 1, 0, 0, 8'h00, 0, 1, "lat0"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 1, "lat1"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 1, "lat2"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 1, 1, "lat3"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA5, 1, 1, "lat4"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "lat5"));
    // Backpressure with a gap in the input; 55 offered while full is refused,
    // then accepted in the same cycle out_rdy rises.
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 8'h00, 0, 1, "bp0"));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 1, 1, "bp1"));
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 8'h00, 1, 1, "bp2"));
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 8'h00, 2, 1, "bp3"));
    vecs.push_back(mk(1, 8'h44, 0, 0, 1, 8'h11, 3, 1, "bp4"));
    vecs.push_back(mk(1, 8'h55, 0, 0, 1, 8'h11, 4, 0, "bp5"));
    vecs.push_back(mk(1, 8'h55, 1, 0, 1, 8'h11, 4, 1, "bp6"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h22, 4, 1, "bp7"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h33, 3, 1, "bp8"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h44, 2, 1, "bp9"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h55, 1, 1, "bp10"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "bp11"));
    // Flush with three words held: AA is delivered, DD is dropped and must
    // never appear afterwards.
    vecs.push_back(mk(1, 8'hAA, 0, 0, 0, 8'h00, 0, 1, "fl0"));
    vecs.push_back(mk(1, 8'hBB, 0, 0, 0, 8'h00, 1, 1, "fl1"));
    vecs.push_back(mk(1, 8'hCC, 0, 0, 0, 8'h00, 2, 1, "fl2"));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h00, 3, 1, "fl3"));
    vecs.push_back(mk(1, 8'hDD, 1, 1, 1, 8'hAA, 3, 0, "fl4"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "fl5"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "fl6"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "fl7"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "fl8"));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, "fl9"));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].in_vld, vecs[i].indata, vecs[i].out_rdy, vecs[i].flush);
      #2;
      checkState(vecs[i].tag, vecs[i].exp_vld, vecs[i].exp_data,
                 vecs[i].exp_count, vecs[i].exp_rdy);
      nextCycle();
    end

    // ---- Streaming: 01..10 back to back with the output always ready ----
    for (int t = 0; t <= 20; t++) begin
      logic       ev;
      logic [7:0] ed;
      int         ec;
      applyStimulus(t < 16, 8'(t + 1), 1'b1, 1'b0);
      ev = (t >= 4) && (t <= 19);
      ed = ev ? 8'(t - 3) : 8'h00;
      ec = (t <= 16) ? ((t < 4) ? t : 4) : (4 - (t - 16));
      #2;
      checkState($sformatf("stream%0d", t), ev, ed, ec, 1'b1);
      nextCycle();
    end

    // ---- Asynchronous reset while full ----
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'(8'h61 + i), 1'b0, 1'b0);
      nextCycle();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    #2;
    checkState("arst_full", 1'b1, 8'h61, 4, 1'b0);
    rst_n = 1'b0;
    #1;
    checkState("arst_asserted", 1'b0, 8'h00, 0, 1'b1);
    #1;
    rst_n = 1'b1;
    #1;
    checkState("arst_released", 1'b0, 8'h00, 0, 1'b1);
    nextCycle();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      #2;
      checkState($sformatf("arst_idle%0d", i), 1'b0, 8'h00, 0, 1'b1);
      nextCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
